// File: rtl/x87_decode_stream.sv
// Streaming x87 opcode decoder (9B / D8..DF+ModRM) feeding a small command FIFO.
// Optional X87_DEC_MODRM_EN: stores the raw ModRM byte per entry and exposes out_modrm_o.
module x87_decode_stream #(
  parameter int unsigned CMD_W = 6,
  parameter int unsigned DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid_i,
  output logic                         in_ready_o,
  input  logic [7:0]                   in_byte_i,
  input  logic                         in_flush_i,
  output logic                         out_valid_o,
  input  logic                         out_ready_i,
  output logic [CMD_W-1:0]             out_cmd_o,
  output logic [2:0]                   out_idx_o,
  output logic                         out_mem_o,
`ifdef X87_DEC_MODRM_EN
  output logic [7:0]                   out_modrm_o,
`endif
  output logic [$clog2(DEPTH+1)-1:0]   level_o,
  output logic                         in_ill_o
);

  localparam int unsigned PTR_W  = $clog2(DEPTH);
  localparam int unsigned LVL_W  = $clog2(DEPTH+1);
  localparam bit          EXT_EN = (CMD_W >= 6);

  typedef enum logic {S_OP1, S_OP2} state_t;

  typedef struct packed {
    logic [CMD_W-1:0] cmd;
    logic [2:0]       idx;
    logic             mem;
`ifdef X87_DEC_MODRM_EN
    logic [7:0]       modrm;
`endif
  } entry_t;

  state_t             state_q, state_d;
  logic [2:0]         op1_q, op1_d;
  logic               ill_q, ill_d;
  entry_t             mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_q, rd_q;
  logic [LVL_W-1:0]   count_q;
  logic               acc, push, pop;
  entry_t             push_ent, head;

  // Map low opcode bits (D8+op) and ModRM to a command code.
  function automatic logic [CMD_W-1:0] decode(input logic [2:0] op, input logic [7:0] m);
    logic [5:0] c;
    logic       ext;
    logic [2:0] rg, rm;
    c   = 6'd31;
    ext = 1'b0;
    rg  = m[5:3];
    rm  = m[2:0];
    if (m[7:6] != 2'b11) begin
      if (op == 3'd1) begin
        case (rg)
          3'd0:    c = 6'd6;
          3'd3:    c = 6'd8;
          3'd5:    c = 6'd3;
          3'd7:    c = 6'd4;
          default: c = 6'd31;
        endcase
      end else if (op == 3'd5) begin
        case (rg)
          3'd0:    c = 6'd7;
          3'd3:    c = 6'd9;
          default: c = 6'd31;
        endcase
      end
    end else begin
      case (op)
        3'd0: begin
          case (rg)
            3'd0: c = 6'd20;
            3'd1: c = 6'd21;
            3'd2: c = 6'd23;
            3'd3: c = 6'd26;
            3'd4: c = 6'd24;
            3'd5: c = 6'd25;
            3'd6: c = 6'd22;
            default: begin c = 6'd34; ext = 1'b1; end
          endcase
        end
        3'd1: begin
          if (rg == 3'd0)                    c = 6'd10;
          else if (rg == 3'd1)               c = 6'd11;
          else if (rg == 3'd4 && rm == 3'd0) begin c = 6'd36; ext = 1'b1; end
          else if (rg == 3'd4 && rm == 3'd1) begin c = 6'd37; ext = 1'b1; end
          else if (rg == 3'd5 && rm == 3'd0) begin c = 6'd39; ext = 1'b1; end
          else if (rg == 3'd5 && rm == 3'd6) begin c = 6'd38; ext = 1'b1; end
        end
        3'd3: if (m == 8'hE3) c = 6'd2;
        3'd5: if (rg == 3'd3) c = 6'd12;
        3'd6: begin
          case (rg)
            3'd0: c = 6'd27;
            3'd1: c = 6'd28;
            3'd7: c = 6'd29;
            3'd5: begin c = 6'd32; ext = 1'b1; end
            3'd4: begin c = 6'd33; ext = 1'b1; end
            3'd6: begin c = 6'd35; ext = 1'b1; end
            3'd3: if (rm == 3'd1) begin c = 6'd40; ext = 1'b1; end
            default: c = 6'd31;
          endcase
        end
        3'd7: if (m == 8'hE0) c = 6'd1;
        default: c = 6'd31;
      endcase
    end
    if (ext && !EXT_EN) c = 6'd31;
    return CMD_W'(c);
  endfunction

  assign in_ready_o  = (count_q != LVL_W'(DEPTH)) && !in_flush_i;
  assign out_valid_o = (count_q != '0);
  assign acc         = in_valid_i && in_ready_o;
  assign pop         = out_valid_o && out_ready_i && !in_flush_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_OP1;
      op1_q   <= '0;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op1_q   <= op1_d;
      ill_q   <= ill_d;
    end
  end

  // Byte assembly: 9B pushes alone, D8..DF waits for ModRM, anything else is dropped.
  always_comb begin
    state_d  = state_q;
    op1_d    = op1_q;
    ill_d    = 1'b0;
    push     = 1'b0;
    push_ent = '0;
    if (in_flush_i) begin
      state_d = S_OP1;
    end else if (acc) begin
      case (state_q)
        S_OP1: begin
          if (in_byte_i == 8'h9B) begin
            push         = 1'b1;
            push_ent.cmd = CMD_W'(5);
          end else if (in_byte_i[7:3] == 5'b11011) begin
            op1_d   = in_byte_i[2:0];
            state_d = S_OP2;
          end else begin
            ill_d = 1'b1;
          end
        end
        default: begin
          push         = 1'b1;
          push_ent.cmd = decode(op1_q, in_byte_i);
          push_ent.idx = in_byte_i[2:0];
          push_ent.mem = (in_byte_i[7:6] != 2'b11);
`ifdef X87_DEC_MODRM_EN
          push_ent.modrm = in_byte_i;
`endif
          state_d = S_OP1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else if (in_flush_i) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      if (push) begin
        mem_q[wr_q] <= push_ent;
        wr_q        <= wr_q + PTR_W'(1);
      end
      if (pop) rd_q <= rd_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + LVL_W'(1);
        2'b01:   count_q <= count_q - LVL_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign head      = mem_q[rd_q];
  assign out_cmd_o = head.cmd;
  assign out_idx_o = head.idx;
  assign out_mem_o = head.mem;
`ifdef X87_DEC_MODRM_EN
  assign out_modrm_o = head.modrm;
`endif
  assign level_o   = count_q;
  assign in_ill_o  = ill_q;

endmodule

// File: tb/tb_x87_decode_stream.sv
// Self-checking bench for x87_decode_stream: directed steps plus random bytes
// against a queue-based reference model driven by the opcode table.
module tb_x87_decode_stream;

  localparam int CMD_W = 6;
  localparam int DEPTH = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid, in_ready, in_flush, out_valid, out_ready, out_mem, in_ill;
  logic [7:0]       in_byte;
  logic [CMD_W-1:0] out_cmd;
  logic [2:0]       out_idx;
  logic [2:0]       level;
`ifdef X87_DEC_MODRM_EN
  logic [7:0]       out_modrm;
`endif

  always #5 clk = ~clk;

  x87_decode_stream #(.CMD_W(CMD_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .in_byte_i(in_byte),
    .in_flush_i(in_flush), .out_valid_o(out_valid), .out_ready_i(out_ready),
    .out_cmd_o(out_cmd), .out_idx_o(out_idx), .out_mem_o(out_mem),
`ifdef X87_DEC_MODRM_EN
    .out_modrm_o(out_modrm),
`endif
    .level_o(level), .in_ill_o(in_ill)
  );

  typedef struct { int cmd; int idx; int mem; } ent_t;

  int         total = 0;
  int         bad   = 0;
  ent_t       q[$];
  bit         pend;
  logic [7:0] opb;
  bit         exp_ill;

  function automatic int ref_cmd(input logic [7:0] op, input logic [7:0] m);
    int  s, row;
    bit  ext;
    int  c;
    ext = (CMD_W >= 6);
    c   = 31;
    if (op == 8'hDF && m == 8'hE0) return 1;
    if (op == 8'hDB && m == 8'hE3) return 2;
    if (m < 8'hC0) begin
      s = (m / 8) % 8;
      if (op == 8'hD9 && s == 5) c = 3;
      if (op == 8'hD9 && s == 7) c = 4;
      if (op == 8'hD9 && s == 0) c = 6;
      if (op == 8'hDD && s == 0) c = 7;
      if (op == 8'hD9 && s == 3) c = 8;
      if (op == 8'hDD && s == 3) c = 9;
      return c;
    end
    row = m - (m % 8);
    if (op == 8'hD9) begin
      if (row == 'hC0) c = 10;
      if (row == 'hC8) c = 11;
      if (m == 8'hE0) c = ext ? 36 : 31;
      if (m == 8'hE1) c = ext ? 37 : 31;
      if (m == 8'hEE) c = ext ? 38 : 31;
      if (m == 8'hE8) c = ext ? 39 : 31;
    end
    if (op == 8'hDD && row == 'hD8) c = 12;
    if (op == 8'hD8) begin
      if (row == 'hC0) c = 20;
      if (row == 'hC8) c = 21;
      if (row == 'hF0) c = 22;
      if (row == 'hD0) c = 23;
      if (row == 'hE0) c = 24;
      if (row == 'hE8) c = 25;
      if (row == 'hD8) c = 26;
      if (row == 'hF8) c = ext ? 34 : 31;
    end
    if (op == 8'hDE) begin
      if (row == 'hC0) c = 27;
      if (row == 'hC8) c = 28;
      if (row == 'hF8) c = 29;
      if (row == 'hE8) c = ext ? 32 : 31;
      if (row == 'hE0) c = ext ? 33 : 31;
      if (row == 'hF0) c = ext ? 35 : 31;
      if (m == 8'hD9)  c = ext ? 40 : 31;
    end
    return c;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock: drive, compare against model, take the edge, advance the model.
  task automatic cyc(input bit v, input logic [7:0] b, input bit rdy, input bit fl);
    bit acc, pop;
    ent_t e;
    in_valid = v; in_byte = b; out_ready = rdy; in_flush = fl;
    #1;
    chk("level", 32'(level), 32'(q.size()));
    chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
    chk("in_ready", 32'(in_ready), 32'(q.size() < DEPTH && !fl));
    chk("in_ill", 32'(in_ill), 32'(exp_ill));
    if (q.size() != 0) begin
      chk("head_cmd", 32'(out_cmd), 32'(q[0].cmd));
      chk("head_idx", 32'(out_idx), 32'(q[0].idx));
      chk("head_mem", 32'(out_mem), 32'(q[0].mem));
    end
    acc = v && (q.size() < DEPTH) && !fl;
    pop = (q.size() != 0) && rdy;
    @(posedge clk);
    #1;
    exp_ill = 1'b0;
    if (fl) begin
      q.delete();
      pend = 1'b0;
    end else begin
      if (pop) q.delete(0);
      if (acc) begin
        if (!pend) begin
          if (b == 8'h9B) begin
            e = '{5, 0, 0};
            q.push_back(e);
          end else if (b >= 8'hD8 && b <= 8'hDF) begin
            pend = 1'b1;
            opb  = b;
          end else begin
            exp_ill = 1'b1;
          end
        end else begin
          e = '{ref_cmd(opb, b), b % 8, (b < 8'hC0) ? 1 : 0};
          q.push_back(e);
          pend = 1'b0;
        end
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 8'h00, 1'b1, 1'b0);
  endtask

  initial begin
    bit         fl, v, rdy;
    logic [7:0] b;
    int         r;
    rst_n = 1'b0; in_valid = 1'b0; in_byte = 8'h00; in_flush = 1'b0; out_ready = 1'b0;
    pend = 1'b0; opb = 8'h00; exp_ill = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_level", 32'(level), 0);
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_ill", 32'(in_ill), 0);
    chk("rst_cmd", 32'(out_cmd), 0);
    chk("rst_idx", 32'(out_idx), 0);
    chk("rst_mem", 32'(out_mem), 0);
    rst_n = 1'b1;

    // D9,C3 -> FLD ST(3)
    cyc(1, 8'hD9, 1, 0); cyc(1, 8'hC3, 1, 0);
    chk("fld_cmd", 32'(out_cmd), 10);
    chk("fld_idx", 32'(out_idx), 3);
    chk("fld_mem", 32'(out_mem), 0);
    chk("fld_level", 32'(level), 1);
    idle(2);

    // 9B then DF,E0 popped in order
    cyc(1, 8'h9B, 0, 0); cyc(1, 8'hDF, 0, 0); cyc(1, 8'hE0, 0, 0);
    chk("fwait_cmd", 32'(out_cmd), 5);
    chk("fwait_idx", 32'(out_idx), 0);
    chk("two_level", 32'(level), 2);
    cyc(0, 8'h00, 1, 0);
    chk("fstsw_cmd", 32'(out_cmd), 1);
    idle(2);

    // Extended FLD1 and memory FLDCW
    cyc(1, 8'hD9, 1, 0); cyc(1, 8'hE8, 1, 0);
    chk("fld1_cmd", 32'(out_cmd), 39);
    cyc(1, 8'hD9, 1, 0); cyc(1, 8'h2D, 1, 0);
    chk("fldcw_cmd", 32'(out_cmd), 3);
    chk("fldcw_mem", 32'(out_mem), 1);
    idle(2);

    // Fill to DEPTH, stall, then drain
    for (int i = 0; i < DEPTH; i++) cyc(1, 8'h9B, 0, 0);
    chk("full_level", 32'(level), DEPTH);
    chk("full_ready", 32'(in_ready), 0);
    cyc(1, 8'h9B, 0, 0);
    cyc(1, 8'h9B, 1, 0);
    cyc(1, 8'h9B, 1, 0);
    idle(6);

    // Flush discards partial opcode
    cyc(1, 8'hD8, 1, 0); cyc(0, 8'h00, 1, 1); cyc(1, 8'hC1, 1, 0);
    chk("flush_ill", 32'(in_ill), 1);
    chk("flush_level", 32'(level), 0);
    idle(1);

    // Reset mid-operation
    cyc(1, 8'h9B, 0, 0); cyc(1, 8'hD8, 0, 0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_level", 32'(level), 0);
    chk("mid_rst_valid", 32'(out_valid), 0);
    chk("mid_rst_cmd", 32'(out_cmd), 0);
    q.delete(); pend = 1'b0; exp_ill = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc(1, 8'hD9, 0, 0); cyc(1, 8'hC0, 0, 0);
    chk("post_rst_cmd", 32'(out_cmd), 10);
    idle(2);

    // Simultaneous push and pop at level 2
    cyc(1, 8'h9B, 0, 0); cyc(1, 8'hDD, 0, 0); cyc(1, 8'hD9, 0, 0);
    cyc(1, 8'hDE, 0, 0);
    chk("pp_level_before", 32'(level), 2);
    cyc(1, 8'hC1, 1, 0);
    chk("pp_level_after", 32'(level), 2);
    chk("pp_head_cmd", 32'(out_cmd), 12);
    idle(4);

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      r = int'($urandom_range(0, 99));
      if (pend) b = 8'($urandom_range(0, 255));
      else if (r < 60) b = 8'hD8 + 8'($urandom_range(0, 7));
      else if (r < 75) b = 8'h9B;
      else b = 8'($urandom_range(0, 255));
      v   = ($urandom_range(0, 99) < 80);
      rdy = ($urandom_range(0, 99) < 60);
      fl  = ($urandom_range(0, 99) < 3);
      cyc(v, b, rdy, fl);
    end
    idle(6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
